// File: rtl/tap_capture_pkg.sv
// tap_capture_pkg: shared types and defaults for the tap capture sequencer.
//   state_t     - 2-bit scan FSM state encoding (IDLE, SCAN, DONE)
//   NUM_TAPS_DEF - default number of chain registers
//   TAP_W_DEF    - default tap index width, derived via tap_w()
package tap_capture_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t SCAN = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam int unsigned NUM_TAPS_DEF = 5;

  // Index width for n taps; never narrower than one bit.
  function automatic int unsigned tap_w(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int unsigned TAP_W_DEF = tap_w(NUM_TAPS_DEF);

endpackage

// File: rtl/tap_capture_seq_if.sv
// tap_capture_seq_if: data/handshake bundle for tap_capture_seq.
//   in    - serial data into the launch chain
//   start - scan request
//   out   - captured tap bit
//   tap   - index of the tap held in out
//   valid - out/tap hold a fresh capture
//   busy  - scan in progress
// master drives in/start (the environment), slave is the sequencer.
interface tap_capture_seq_if #(
  parameter int unsigned TAP_W = 3
);
  logic             in;
  logic             start;
  logic             out;
  logic [TAP_W-1:0] tap;
  logic             valid;
  logic             busy;

  modport master (
    output in,
    output start,
    input  out,
    input  tap,
    input  valid,
    input  busy
  );

  modport slave (
    input  in,
    input  start,
    output out,
    output tap,
    output valid,
    output busy
  );
endinterface

// File: rtl/tap_shift_chain.sv
// tap_shift_chain: serial launch register chain.
//   clk - rising-edge clock
//   rst - asynchronous active-high reset, clears every tap
//   in  - serial data, shifted into sr[0] every edge
//   sr  - tap outputs, sr[i] is in delayed by i+1 edges
// One generate block per tap so each launch flop keeps a stable hierarchical
// name (g_tap[i].q) for timing constraints.
module tap_shift_chain #(
  parameter int unsigned NUM_TAPS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in,
  output logic [NUM_TAPS-1:0] sr
);

  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
    logic d;
    logic q;

    if (i == 0) begin : g_head
      assign d = in;
    end else begin : g_body
      assign d = sr[i-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q <= 1'b0;
      end else begin
        q <= d;
      end
    end

    assign sr[i] = q;
  end

endmodule

// File: rtl/tap_capture_seq.sv
// tap_capture_seq: scans every tap of a serial launch chain through one shared
// select mux into a single capture register.
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - slave side of tap_capture_seq_if:
//         in/start in, out/tap/valid/busy out (all outputs registered)
// A start accepted in IDLE launches a scan: tap 0..NUM_TAPS-1 are captured on
// consecutive edges, then one DONE cycle returns to IDLE. Because the chain
// shifts in lockstep with the scan index, every capture of one scan sees the
// bit that was on `in` at the edge that accepted start.
module tap_capture_seq
  import tap_capture_pkg::*;
#(
  parameter int unsigned NUM_TAPS = NUM_TAPS_DEF,
  parameter int unsigned TAP_W    = TAP_W_DEF
) (
  input logic              clk,
  input logic              rst,
  tap_capture_seq_if.slave bus
);

  localparam logic [TAP_W-1:0] LAST_IDX = TAP_W'(NUM_TAPS - 1);

  logic [NUM_TAPS-1:0] sr;

  state_t           state_q, state_d;
  logic [TAP_W-1:0] idx_q, idx_d;
  logic             out_q, out_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             sel_bit;

  tap_shift_chain #(
    .NUM_TAPS(NUM_TAPS)
  ) u_chain (
    .clk(clk),
    .rst(rst),
    .in (bus.in),
    .sr (sr)
  );

  // Shared NUM_TAPS:1 select mux; written as a compare loop so that index
  // codes beyond NUM_TAPS-1 (non-power-of-two chains) decode to 0 cleanly.
  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (idx_q == TAP_W'(i)) begin
        sel_bit = sr[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    out_d   = out_q;
    tap_d   = tap_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (bus.start) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        out_d   = sel_bit;
        tap_d   = idx_q;
        valid_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + TAP_W'(1);
        end
      end
      DONE: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    // busy is its own flop so the output has no decode logic behind it.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      out_q   <= 1'b0;
      tap_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      tap_q   <= tap_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.tap   = tap_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_tap_capture_seq.sv
// tb_tap_capture_seq: drives a 5-tap and a 2-tap sequencer with identical
// stimulus and checks every output of both against a timeline model: a scan
// accepted at edge s yields tap k with the bit sampled at s after edge s+1+k,
// then a single idle-return edge; start is only taken when no scan is open.
module tb_tap_capture_seq;

  localparam int NT [2] = '{5, 2};

  logic clk;
  logic rst;

  tap_capture_seq_if #(.TAP_W(3)) bus5 ();
  tap_capture_seq_if #(.TAP_W(1)) bus2 ();

  tap_capture_seq #(
    .NUM_TAPS(5),
    .TAP_W   (3)
  ) dut5 (
    .clk(clk),
    .rst(rst),
    .bus(bus5)
  );

  tap_capture_seq #(
    .NUM_TAPS(2),
    .TAP_W   (1)
  ) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance.
  int edge_cnt;
  bit act     [2];
  int s_edge  [2];
  bit cap_bit [2];
  bit e_out   [2];
  int e_tap   [2];
  bit e_valid [2];
  bit e_busy  [2];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      act[j]     = 1'b0;
      e_out[j]   = 1'b0;
      e_tap[j]   = 0;
      e_valid[j] = 1'b0;
      e_busy[j]  = 1'b0;
    end
  endtask

  task automatic model_edge(input bit in_v, input bit start_v);
    int d;
    if (rst) begin
      model_reset();
      return;
    end
    edge_cnt++;
    for (int j = 0; j < 2; j++) begin
      if (act[j]) begin
        d = edge_cnt - s_edge[j];
        if (d <= NT[j]) begin
          e_valid[j] = 1'b1;
          e_tap[j]   = d - 1;
          e_out[j]   = cap_bit[j];
          e_busy[j]  = 1'b1;
        end else begin
          e_valid[j] = 1'b0;
          e_busy[j]  = 1'b0;
          act[j]     = 1'b0;
        end
      end else if (start_v) begin
        act[j]     = 1'b1;
        s_edge[j]  = edge_cnt;
        cap_bit[j] = in_v;
        e_busy[j]  = 1'b1;
        e_valid[j] = 1'b0;
      end
    end
  endtask

  task automatic compare_all(input string ph);
    int got_out [2];
    int got_tap [2];
    int got_val [2];
    int got_bsy [2];
    got_out[0] = int'(bus5.out);
    got_tap[0] = int'(bus5.tap);
    got_val[0] = int'(bus5.valid);
    got_bsy[0] = int'(bus5.busy);
    got_out[1] = int'(bus2.out);
    got_tap[1] = int'(bus2.tap);
    got_val[1] = int'(bus2.valid);
    got_bsy[1] = int'(bus2.busy);
    for (int j = 0; j < 2; j++) begin
      check_eq($sformatf("%s n%0d valid", ph, NT[j]), got_val[j], int'(e_valid[j]));
      check_eq($sformatf("%s n%0d busy", ph, NT[j]), got_bsy[j], int'(e_busy[j]));
      check_eq($sformatf("%s n%0d out", ph, NT[j]), got_out[j], int'(e_out[j]));
      check_eq($sformatf("%s n%0d tap", ph, NT[j]), got_tap[j], e_tap[j]);
    end
  endtask

  // Called at a negedge; drives inputs, advances one edge, checks at the next negedge.
  task automatic step(input string ph, input bit in_v, input bit start_v);
    bus5.in    = in_v;
    bus5.start = start_v;
    bus2.in    = in_v;
    bus2.start = start_v;
    @(posedge clk);
    model_edge(in_v, start_v);
    @(negedge clk);
    compare_all(ph);
  endtask

  initial begin
    bit tog;
    rst        = 1'b1;
    bus5.in    = 1'b0;
    bus5.start = 1'b0;
    bus2.in    = 1'b0;
    bus2.start = 1'b0;
    edge_cnt   = 0;
    model_reset();

    // Reset state.
    @(negedge clk);
    compare_all("reset");
    step("reset", 1'b1, 1'b1);
    rst = 1'b0;

    // Basic scan with steady 1.
    for (int c = 0; c < 3; c++) step("idle", 1'b1, 1'b0);
    step("basic", 1'b1, 1'b1);
    for (int c = 0; c < 8; c++) step("basic", 1'b1, 1'b0);

    // Toggling input, start taken while in=0.
    tog = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step("toggle", tog, 1'b0);
      tog = ~tog;
    end
    step("toggle", 1'b0, 1'b1);
    tog = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step("toggle", tog, 1'b0);
      tog = ~tog;
    end

    // Start held high continuously.
    for (int c = 0; c < 30; c++) step("hold", 1'($urandom_range(0, 1)), 1'b1);
    for (int c = 0; c < 8; c++) step("hold", 1'b0, 1'b0);

    // Reset mid-scan: asynchronous assertion between edges.
    step("midrst", 1'b1, 1'b1);
    step("midrst", 1'b1, 1'b0);
    step("midrst", 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("midrst async");
    @(negedge clk);
    compare_all("midrst held");
    step("midrst", 1'b1, 1'b1);
    step("midrst", 1'b1, 1'b0);
    rst = 1'b0;
    step("postrst", 1'b1, 1'b0);
    step("postrst", 1'b1, 1'b1);
    for (int c = 0; c < 8; c++) step("postrst", 1'b0, 1'b0);

    // Random traffic.
    for (int c = 0; c < 300; c++) begin
      step("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
